// File: rtl/sccomp_run_monitor.sv
// Run-control and state-dump unit for sccomp: arms on start, stops on a PC hit-count
// or cycle budget, holds the CPU and streams pc/instr/cycles/registers over valid/ready.
module sccomp_run_monitor #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 5,
  localparam int IDX_W = $clog2(NREG + 3)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [PC_W-1:0]   stop_pc,
  input  logic [CNT_W-1:0]  hit_target,
  input  logic [CNT_W-1:0]  cycle_limit,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   instr,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic              cpu_halt,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [IDX_W-1:0]  dump_idx,
  output logic              busy,
  output logic              done,
  output logic [1:0]        stop_cause,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_DONE} state_t;

  // wr_idx is one bit wider than dump_idx so it can hold the one-past-last value.
  localparam logic [IDX_W:0]   NWORDS   = (IDX_W + 1)'(NREG + 3);
  localparam logic [IDX_W:0]   FIRST_RG = (IDX_W + 1)'(3);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG + 2);

  state_t            state, state_nx;
  logic [PC_W-1:0]   stop_pc_q, snap_pc, snap_instr;
  logic [CNT_W-1:0]  hit_target_q, cycle_limit_q, hit_cnt, snap_cnt;
  logic [IDX_W:0]    wr_idx, sel_idx;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] word;
  logic              arm, match, pc_stop, timeout, load, last_acc;

  assign arm      = start && (state == S_IDLE || state == S_DONE);
  assign match    = (pc == stop_pc_q);
  assign cnt_inc  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
  assign pc_stop  = match && (hit_target_q != '0) && (hit_cnt + CNT_W'(1) == hit_target_q);
  assign timeout  = (cycle_limit_q != '0) && (cycle_count + CNT_W'(1) == cycle_limit_q);
  assign load     = (state == S_DUMP) && (!dump_valid || dump_ready) && (wr_idx < NWORDS);
  assign last_acc = (state == S_DUMP) && dump_valid && dump_ready && (dump_idx == LAST_IDX);

  assign sel_idx  = wr_idx - FIRST_RG;
  assign reg_sel  = (state == S_DUMP && wr_idx >= FIRST_RG && wr_idx < NWORDS)
                    ? SEL_W'(sel_idx) : '0;

  assign busy     = (state == S_RUN) || (state == S_DUMP);
  assign cpu_halt = (state == S_DUMP) || (state == S_DONE);
  assign done     = (state == S_DONE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    word = reg_data;
    case (wr_idx)
      (IDX_W + 1)'(0): word = DATA_W'(snap_pc);
      (IDX_W + 1)'(1): word = DATA_W'(snap_instr);
      (IDX_W + 1)'(2): word = DATA_W'(snap_cnt);
      default:         word = reg_data;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_RUN;
      S_RUN:          if (pc_stop || timeout) state_nx = S_DUMP;
      S_DUMP:         if (last_acc) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stop_pc_q     <= '0;
      hit_target_q  <= '0;
      cycle_limit_q <= '0;
      hit_cnt       <= '0;
      cycle_count   <= '0;
      stop_cause    <= '0;
      snap_pc       <= '0;
      snap_instr    <= '0;
      snap_cnt      <= '0;
      wr_idx        <= '0;
      dump_valid    <= 1'b0;
      dump_data     <= '0;
      dump_idx      <= '0;
    end else begin
      if (arm) begin
        stop_pc_q     <= stop_pc;
        hit_target_q  <= hit_target;
        cycle_limit_q <= cycle_limit;
        hit_cnt       <= '0;
        cycle_count   <= '0;
        stop_cause    <= '0;
        wr_idx        <= '0;
        dump_valid    <= 1'b0;
      end
      if (state == S_RUN) begin
        cycle_count <= cnt_inc;
        if (match) hit_cnt <= hit_cnt + CNT_W'(1);
        if (pc_stop || timeout) begin
          snap_pc    <= pc;
          snap_instr <= instr;
          snap_cnt   <= cnt_inc;
          stop_cause <= pc_stop ? 2'd1 : 2'd2;
          wr_idx     <= '0;
        end
      end
      if (load) begin
        dump_data  <= word;
        dump_idx   <= wr_idx[IDX_W-1:0];
        dump_valid <= 1'b1;
        wr_idx     <= wr_idx + (IDX_W + 1)'(1);
      end else if (last_acc) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sccomp_run_monitor.md
Name: sccomp_run_monitor

Overview:
Synthesizable run-control and state-dump unit for the single-cycle CPU `sccomp`. It arms on `start` and watches the CPU PC each cycle. It stops the run on a programmable PC hit-count or a cycle-limit timeout, then holds the CPU with `cpu_halt`. While the CPU is held it walks `reg_sel` over the register file and streams PC, instruction, cycle count and every register over a valid/ready port. This replaces the fixed stop-PC dump logic and is usable on FPGA as well as in simulation.

Parameters:
PC_W, 32, width of pc, instr, stop_pc.
DATA_W, 32, width of reg_data and dump_data; must be >= PC_W and >= CNT_W.
NREG, 32, number of registers dumped (reg_sel values 0..NREG-1).
CNT_W, 32, width of cycle counter, cycle_limit and hit counter.
SEL_W, 5, width of reg_sel; 2**SEL_W >= NREG.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rstn  in  1  asynchronous active-low reset.
start  in  1  one-cycle arm pulse; sampled in IDLE or DONE only.
stop_pc  in  PC_W  PC value to match; sampled at start.
hit_target  in  CNT_W  number of stop_pc matches that stops the run; 0 disables PC stop; sampled at start.
cycle_limit  in  CNT_W  run-cycle budget; 0 disables timeout; sampled at start.
pc  in  PC_W  CPU current PC.
instr  in  PC_W  CPU current instruction.
reg_sel  out  SEL_W  register-file read select to `sccomp`.
reg_data  in  DATA_W  register-file read data; combinational from reg_sel.
cpu_halt  out  1  CPU clock-enable low / hold request.
dump_valid  out  1  dump word available.
dump_ready  in  1  consumer accepts word.
dump_data  out  DATA_W  dump word.
dump_idx  out  $clog2(NREG+3)  index of dump_data.
busy  out  1  state is RUN or DUMP.
done  out  1  state is DONE.
stop_cause  out  2  0 none, 1 PC hit, 2 timeout.
cycle_count  out  CNT_W  RUN cycles elapsed.

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs 0: reg_sel, cpu_halt, dump_valid, dump_data, dump_idx, busy, done, stop_cause, cycle_count. Internal counters 0. Reset mid-RUN or mid-DUMP aborts immediately; there is no partial-stream recovery.
- States: IDLE, RUN, DUMP, DONE.
- IDLE --start--> RUN. On this edge: latch stop_pc, hit_target, cycle_limit; clear cycle_count, hit_cnt and stop_cause.
- RUN, each edge:
  - cycle_count increments and saturates at all-ones.
  - A match is pc==stop_pc. On a match, hit_cnt increments.
  - PC stop: match && hit_target!=0 && hit_cnt+1==hit_target.
  - Timeout: cycle_limit!=0 && cycle_count+1==cycle_limit.
  - On either stop condition, go to DUMP; cpu_halt=1 from the next cycle, so the stopping instruction's pc/instr is the one captured.
  - On the same edge, latch the snapshot: pc into word0, instr into word1, cycle_count+1 into word2.
  - If both conditions hold on the same edge, stop_cause=1 (PC wins).
  - If hit_target=0 and cycle_limit=0, the run never stops.
- DUMP:
  - Stream NREG+3 words: idx0 pc, idx1 instr, idx2 cycle_count (zero-extended), idx 3+k register k for k=0..NREG-1.
  - Load counter wr_idx starts at 0. reg_sel = wr_idx-3 while wr_idx>=3, else 0.
  - When (!dump_valid || dump_ready) and wr_idx<NREG+3: load dump_data/dump_idx for wr_idx, set dump_valid=1, increment wr_idx. Back-to-back streaming runs at one word per cycle with ready held high.
  - While dump_valid && !dump_ready, dump_data and dump_idx hold stable.
  - When the last word (idx NREG+2) is accepted: dump_valid=0, go to DONE.
- DONE: cpu_halt=1, done=1. stop_cause and cycle_count are held. start re-arms exactly as from IDLE, and cpu_halt drops on that edge.
- start is ignored in RUN and DUMP.
- busy = RUN|DUMP. cpu_halt = DUMP|DONE.

Test Plan:
- Basic stop: stop_pc=0x28, hit_target=1, cycle_limit=0; pc=0,4,...,0x28 one step per cycle, instr=0xdeadbeef at 0x28.
  - Required: cpu_halt rises the cycle after pc=0x28; stop_cause=1; cycle_count=11.
  - Required stream: 35 words, idx0=0x28, idx1=0xdeadbeef, idx2=11, idx3=reg0=0, idx 3+k = model reg k.
  - Required end: done=1.
- Backpressure: same run with dump_ready toggling 1,0,0,1 repeating. Required: no word lost or duplicated; data/idx stable while stalled; 35 accepts total.
- Timeout: stop_pc=0xFFFC never reached, cycle_limit=5. Required: DUMP entered after 5 RUN cycles; stop_cause=2; word2=5.
- Hit count plus tie: loop pc 0x10,0x14,0x18 repeating, stop_pc=0x18, hit_target=3, cycle_limit=9. Required: stop at 9th cycle; PC hit and timeout coincide; stop_cause=1.
- Reset mid-dump: assert rstn=0 after 7 accepted words. Required: all outputs 0 asynchronously, state IDLE. A new start runs cleanly with idx restarting at 0.
- Re-arm and ignore: start pulsed during RUN has no effect; start in DONE clears done, drops cpu_halt, and cycle_count restarts from 0.
